// File: rtl/ngmux_switch_ctrl.sv
// Sequencer for a glitch-free N-input clock mux: gates the mux output off, moves the
// select while gated, lets it settle, then re-enables. Handles dead sources and fallback.
module ngmux_switch_ctrl #(
    parameter int NUM_CLKS      = 4,
    parameter int SEL_W         = 2,
    parameter int DEFAULT_SEL   = 0,
    parameter int GATE_CYCLES   = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int AUTO_FALLBACK = 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [SEL_W-1:0]    REQ_SEL,
    input  logic                REQ_VALID,
    output logic                REQ_READY,
    input  logic [NUM_CLKS-1:0] CLK_VALID,
    output logic [SEL_W-1:0]    MUX_SEL,
    output logic                GATE_EN,
    output logic [SEL_W-1:0]    CUR_SEL,
    output logic                BUSY,
    output logic                DONE,
    output logic                ERR,
    output logic                LOST
);
    localparam int NSEL  = 1 << SEL_W;
    localparam int MAXC  = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W = $clog2(MAXC + 1);
    localparam logic [SEL_W-1:0] DEF       = SEL_W'(DEFAULT_SEL);
    localparam logic [CNT_W-1:0] GATE_LD   = CNT_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {STARTUP, IDLE, GATE_OFF, SWITCH} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [SEL_W-1:0] mux_sel, mux_nxt, cur_sel, cur_nxt, tgt, tgt_nxt;
    logic             gate_en, gate_nxt, done_nxt, err_nxt, lost_nxt;
    logic             done_q, err_q, lost_q;
    logic [NSEL-1:0]  valid_ext;

    // Unused select codes read as dead sources, so out-of-range requests fall out naturally.
    always_comb begin
        valid_ext                 = '0;
        valid_ext[NUM_CLKS-1:0]   = CLK_VALID;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= STARTUP;
            cnt     <= SETTLE_LD;
            mux_sel <= DEF;
            cur_sel <= DEF;
            tgt     <= DEF;
            gate_en <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            mux_sel <= mux_nxt;
            cur_sel <= cur_nxt;
            tgt     <= tgt_nxt;
            gate_en <= gate_nxt;
            done_q  <= done_nxt;
            err_q   <= err_nxt;
            lost_q  <= lost_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mux_nxt   = mux_sel;
        cur_nxt   = cur_sel;
        tgt_nxt   = tgt;
        gate_nxt  = gate_en;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        lost_nxt  = 1'b0;
        case (state)
            // Also the recovery wait after a loss: the settle count restarts whenever the source drops.
            STARTUP: begin
                if (!valid_ext[cur_sel])  cnt_nxt = SETTLE_LD;
                else if (cnt == '0) begin
                    state_nxt = IDLE;
                    gate_nxt  = 1'b1;
                end else                  cnt_nxt = cnt - CNT_W'(1);
            end
            IDLE: begin
                if (!valid_ext[cur_sel]) begin
                    gate_nxt = 1'b0;
                    lost_nxt = 1'b1;
                    if (AUTO_FALLBACK != 0 && cur_sel != DEF) begin
                        tgt_nxt   = DEF;
                        state_nxt = GATE_OFF;
                        cnt_nxt   = GATE_LD;
                    end else begin
                        state_nxt = STARTUP;
                        cnt_nxt   = SETTLE_LD;
                    end
                end else if (REQ_VALID) begin
                    if (!valid_ext[REQ_SEL])    err_nxt  = 1'b1;
                    else if (REQ_SEL == cur_sel) done_nxt = 1'b1;
                    else begin
                        tgt_nxt   = REQ_SEL;
                        gate_nxt  = 1'b0;
                        state_nxt = GATE_OFF;
                        cnt_nxt   = GATE_LD;
                    end
                end
            end
            GATE_OFF, SWITCH: begin
                if (!valid_ext[tgt]) begin
                    // Target died: retarget the default, or wait it out if the default is the casualty.
                    err_nxt = 1'b1;
                    mux_nxt = DEF;
                    tgt_nxt = DEF;
                    cnt_nxt = SETTLE_LD;
                    if (tgt != DEF && valid_ext[DEF]) state_nxt = SWITCH;
                    else begin
                        state_nxt = STARTUP;
                        cur_nxt   = DEF;
                    end
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else if (state == GATE_OFF) begin
                    mux_nxt   = tgt;
                    state_nxt = SWITCH;
                    cnt_nxt   = SETTLE_LD;
                end else begin
                    gate_nxt  = 1'b1;
                    cur_nxt   = mux_sel;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = STARTUP;
        endcase
    end

    assign REQ_READY = (state == IDLE) && valid_ext[cur_sel];
    assign BUSY      = (state != IDLE);
    assign MUX_SEL   = mux_sel;
    assign CUR_SEL   = cur_sel;
    assign GATE_EN   = gate_en;
    assign DONE      = done_q;
    assign ERR       = err_q;
    assign LOST      = lost_q;
endmodule

// File: tb/tb_ngmux_switch_ctrl.sv
// Bench for ngmux_switch_ctrl: two instances (auto-fallback 2-bit select, no-fallback 3-bit
// select) driven together, compared each cycle against a timestamp-based reference model.
module tb_ngmux_switch_ctrl;
    localparam int GATE = 4, SETTLE = 8, DEF = 0;
    localparam int K_RECOV = 0, K_IDLE = 1, K_SEQ = 2;

    logic       CLK = 1'b0, RST = 1'b1;
    logic [3:0] clk_valid = 4'b1111;
    logic       req_valid = 1'b0;
    logic [2:0] req_sel = '0;
    logic       a_req_valid;

    logic       a_ready, a_gate, a_busy, a_done, a_err, a_lost;
    logic [1:0] a_mux, a_cur;
    logic       b_ready, b_gate, b_busy, b_done, b_err, b_lost;
    logic [2:0] b_mux, b_cur;

    int n_cmp = 0, n_err = 0, cyc = 0;
    int m_kind[2], m_t0[2], m_run[2], m_tgt[2], m_cur[2], m_mux[2];
    bit m_gate[2], m_done[2], m_err[2], m_lost[2];
    int prev_mux[2];
    bit prev_gate[2];

    // Instance a only sees requests that fit its 2-bit select.
    assign a_req_valid = req_valid & ~req_sel[2];

    always #5 CLK = ~CLK;

    ngmux_switch_ctrl #(.NUM_CLKS(4), .SEL_W(2), .DEFAULT_SEL(DEF), .GATE_CYCLES(GATE),
                        .SETTLE_CYCLES(SETTLE), .AUTO_FALLBACK(1)) u_a (
        .CLK(CLK), .RST(RST), .REQ_SEL(req_sel[1:0]), .REQ_VALID(a_req_valid),
        .REQ_READY(a_ready), .CLK_VALID(clk_valid), .MUX_SEL(a_mux), .GATE_EN(a_gate),
        .CUR_SEL(a_cur), .BUSY(a_busy), .DONE(a_done), .ERR(a_err), .LOST(a_lost));

    ngmux_switch_ctrl #(.NUM_CLKS(4), .SEL_W(3), .DEFAULT_SEL(DEF), .GATE_CYCLES(GATE),
                        .SETTLE_CYCLES(SETTLE), .AUTO_FALLBACK(0)) u_b (
        .CLK(CLK), .RST(RST), .REQ_SEL(req_sel), .REQ_VALID(req_valid),
        .REQ_READY(b_ready), .CLK_VALID(clk_valid), .MUX_SEL(b_mux), .GATE_EN(b_gate),
        .CUR_SEL(b_cur), .BUSY(b_busy), .DONE(b_done), .ERR(b_err), .LOST(b_lost));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_kind[d] = K_RECOV; m_run[d] = 0; m_t0[d] = 0;
            m_tgt[d] = DEF; m_cur[d] = DEF; m_mux[d] = DEF;
            m_gate[d] = 0; m_done[d] = 0; m_err[d] = 0; m_lost[d] = 0;
            prev_gate[d] = 0; prev_mux[d] = DEF;
        end
    endtask

    // Sequence progress is measured as elapsed edges since acceptance; recovery as a run of valid edges.
    task automatic model_step(input int d, input logic [3:0] v, input bit rv, input int rs);
        int e;
        m_done[d] = 0; m_err[d] = 0; m_lost[d] = 0;
        case (m_kind[d])
            K_RECOV: begin
                if (!v[m_cur[d]]) m_run[d] = 0;
                else begin
                    m_run[d]++;
                    if (m_run[d] == SETTLE) begin m_kind[d] = K_IDLE; m_gate[d] = 1; end
                end
            end
            K_IDLE: begin
                if (!v[m_cur[d]]) begin
                    m_lost[d] = 1; m_gate[d] = 0;
                    if (d == 0 && m_cur[d] != DEF) begin
                        m_kind[d] = K_SEQ; m_tgt[d] = DEF; m_t0[d] = cyc;
                    end else begin
                        m_kind[d] = K_RECOV; m_run[d] = 0;
                    end
                end else if (rv) begin
                    if (rs >= 4 || !v[rs])    m_err[d] = 1;
                    else if (rs == m_cur[d])  m_done[d] = 1;
                    else begin
                        m_kind[d] = K_SEQ; m_tgt[d] = rs; m_t0[d] = cyc; m_gate[d] = 0;
                    end
                end
            end
            default: begin
                e = cyc - m_t0[d];
                if (!v[m_tgt[d]]) begin
                    m_err[d] = 1; m_mux[d] = DEF;
                    if (m_tgt[d] != DEF && v[DEF]) begin
                        m_tgt[d] = DEF; m_t0[d] = cyc - GATE;
                    end else begin
                        m_tgt[d] = DEF; m_cur[d] = DEF; m_kind[d] = K_RECOV; m_run[d] = 0;
                    end
                end else begin
                    if (e == GATE) m_mux[d] = m_tgt[d];
                    if (e == GATE + SETTLE) begin
                        m_gate[d] = 1; m_cur[d] = m_mux[d]; m_done[d] = 1; m_kind[d] = K_IDLE;
                    end
                end
            end
        endcase
    endtask

    always @(posedge CLK or posedge RST) begin
        if (RST) model_reset();
        else begin
            cyc++;
            model_step(0, clk_valid, a_req_valid, int'(req_sel));
            model_step(1, clk_valid, req_valid, int'(req_sel));
        end
    end

    task automatic check_all();
        string p;
        logic  g, bz, dn, er, ls, rd;
        int    mx, cu;
        for (int d = 0; d < 2; d++) begin
            p  = (d == 0) ? "a" : "b";
            g  = d ? b_gate : a_gate;   bz = d ? b_busy : a_busy;
            dn = d ? b_done : a_done;   er = d ? b_err  : a_err;
            ls = d ? b_lost : a_lost;   rd = d ? b_ready : a_ready;
            mx = d ? int'(b_mux) : int'(a_mux);
            cu = d ? int'(b_cur) : int'(a_cur);
            chk({p, " gate_en"}, 32'(g),  32'(m_gate[d]));
            chk({p, " mux_sel"}, 32'(mx), 32'(m_mux[d]));
            chk({p, " busy"},    32'(bz), 32'(m_kind[d] != K_IDLE));
            chk({p, " done"},    32'(dn), 32'(m_done[d]));
            chk({p, " err"},     32'(er), 32'(m_err[d]));
            chk({p, " lost"},    32'(ls), 32'(m_lost[d]));
            chk({p, " ready"},   32'(rd), 32'(m_kind[d] == K_IDLE && clk_valid[m_cur[d]]));
            if (m_gate[d]) chk({p, " cur_sel"}, 32'(cu), 32'(m_cur[d]));
            if (prev_gate[d] && g) chk({p, " mux_hold"}, 32'(mx), 32'(prev_mux[d]));
            prev_gate[d] = g; prev_mux[d] = mx;
        end
    endtask

    task automatic cycle();
        @(posedge CLK);
        @(negedge CLK);
        check_all();
    endtask

    initial begin
        model_reset();
        #1;
        chk("rst a mux", 32'(a_mux), 0);   chk("rst a cur", 32'(a_cur), 0);
        chk("rst a gate", 32'(a_gate), 0); chk("rst a busy", 32'(a_busy), 1);
        chk("rst a ready", 32'(a_ready), 0);
        chk("rst a pulses", {29'd0, a_done, a_err, a_lost}, 0);
        chk("rst b gate", 32'(b_gate), 0); chk("rst b busy", 32'(b_busy), 1);
        @(negedge CLK); @(negedge CLK);
        RST = 1'b0;

        // Startup: enable after SETTLE valid edges, no DONE.
        repeat (SETTLE - 1) cycle();
        chk("startup gate early", 32'(a_gate), 0);
        cycle();
        chk("startup gate", 32'(a_gate), 1); chk("startup done", 32'(a_done), 0);
        chk("startup busy", 32'(a_busy), 0); chk("startup cur", 32'(a_cur), 0);

        // Normal switch to 2.
        req_valid = 1; req_sel = 3'd2;
        cycle();
        req_valid = 0;
        chk("sw gate off", 32'(a_gate), 0); chk("sw busy", 32'(a_busy), 1);
        for (int k = 1; k <= GATE + SETTLE; k++) begin
            cycle();
            if (k == GATE - 1) chk("sw mux old", 32'(a_mux), 0);
            if (k == GATE)     chk("sw mux new", 32'(a_mux), 2);
            if (k == GATE + SETTLE - 1) chk("sw gate settling", 32'(a_gate), 0);
        end
        chk("sw gate on", 32'(a_gate), 1); chk("sw done", 32'(a_done), 1);
        chk("sw cur", 32'(a_cur), 2);     chk("sw b cur", 32'(b_cur), 2);

        // Rejected requests and same-source request.
        clk_valid = 4'b0111; req_valid = 1; req_sel = 3'd3;
        cycle();
        chk("dead req err a", 32'(a_err), 1); chk("dead req err b", 32'(b_err), 1);
        chk("dead req gate", 32'(a_gate), 1);
        req_sel = 3'd5;
        cycle();
        chk("range req err b", 32'(b_err), 1); chk("range req mux b", 32'(b_mux), 2);
        req_sel = 3'd2;
        cycle();
        chk("same req done", 32'(a_done), 1); chk("same req gate", 32'(a_gate), 1);
        req_valid = 0; clk_valid = 4'b1111;
        cycle();

        // Loss of active source with a simultaneous request.
        clk_valid = 4'b1011; req_valid = 1; req_sel = 3'd1;
        #1;
        chk("loss ready", 32'(a_ready), 0);
        cycle();
        req_valid = 0;
        chk("loss lost a", 32'(a_lost), 1); chk("loss lost b", 32'(b_lost), 1);
        chk("loss gate a", 32'(a_gate), 0);
        repeat (GATE + SETTLE - 1) cycle();
        chk("fallback early", 32'(a_done), 0);
        cycle();
        chk("fallback done", 32'(a_done), 1); chk("fallback cur", 32'(a_cur), 0);
        chk("fallback mux", 32'(a_mux), 0);  chk("nofb gated", 32'(b_gate), 0);
        clk_valid = 4'b1111;
        repeat (SETTLE - 1) cycle();
        chk("nofb early", 32'(b_gate), 0);
        cycle();
        chk("nofb gate", 32'(b_gate), 1); chk("nofb cur", 32'(b_cur), 2);
        chk("nofb done", 32'(b_done), 0);

        // Target dies during SWITCH.
        req_valid = 1; req_sel = 3'd3;
        cycle();
        req_valid = 0;
        repeat (GATE + 1) cycle();
        clk_valid = 4'b0111;
        cycle();
        chk("abort err", 32'(a_err), 1); chk("abort mux", 32'(a_mux), 0);
        chk("abort err b", 32'(b_err), 1);
        repeat (SETTLE - 1) cycle();
        chk("abort gated", 32'(a_gate), 0);
        cycle();
        chk("abort done", 32'(a_done), 1); chk("abort cur", 32'(a_cur), 0);
        chk("abort cur b", 32'(b_cur), 0);
        clk_valid = 4'b1111;

        // Asynchronous reset mid-SWITCH.
        req_valid = 1; req_sel = 3'd1;
        cycle();
        req_valid = 0;
        repeat (GATE + 2) cycle();
        #2 RST = 1'b1;
        #1;
        chk("arst mux", 32'(a_mux), 0); chk("arst gate", 32'(a_gate), 0);
        chk("arst busy", 32'(a_busy), 1); chk("arst mux b", 32'(b_mux), 0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (SETTLE) cycle();
        chk("arst restart", 32'(a_gate), 1);

        // Random traffic; the default source stays alive.
        for (int i = 0; i < 3000; i++) begin
            req_valid = ($urandom_range(0, 3) == 0);
            req_sel   = 3'($urandom_range(0, 7));
            for (int s = 1; s < 4; s++)
                if ($urandom_range(0, 39) == 0) clk_valid[s] = ~clk_valid[s];
            clk_valid[0] = 1'b1;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
